// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: owns the register file write port. Results from the
// ALU and load paths are buffered in per-source FIFOs and merged round-robin
// into at most one registered write per cycle. Writes to register 0 are
// consumed without asserting WE3.

// Per-source FIFO. It has no pass-through, so "full" depends only on the
// stored count. A push into a full FIFO is refused even if a pop happens on
// the same edge.
module rf_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array; the contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally at a power-of-two depth; the count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module rf_writeback_arbiter #(
  parameter  int NUM_REGS   = 32,
  parameter  int REG_WIDTH  = 256,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AW-1:0]        alu_addr,
  input  logic [REG_WIDTH-1:0] alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [AW-1:0]        mem_addr,
  input  logic [REG_WIDTH-1:0] mem_data,
  output logic                 WE3,
  output logic [AW-1:0]        A3,
  output logic [REG_WIDTH-1:0] WD3,
  output logic                 busy
);
  localparam int EW = AW + REG_WIDTH;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e           r_last_grant;
  logic           r_we3;
  logic [AW-1:0]  r_a3;
  logic [REG_WIDTH-1:0] r_wd3;

  logic           w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
  logic [EW-1:0]  w_alu_head, w_mem_head;
  logic           w_grant_alu, w_grant_mem;
  logic [EW-1:0]  w_sel;
  logic [AW-1:0]  w_sel_addr;

  assign alu_ready = rst && !w_alu_full;
  assign mem_ready = rst && !w_mem_full;

  rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (alu_valid && alu_ready),
    .i_wdata ({alu_addr, alu_data}),
    .i_pop   (w_grant_alu),
    .o_rdata (w_alu_head),
    .o_empty (w_alu_empty),
    .o_full  (w_alu_full)
  );

  rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (mem_valid && mem_ready),
    .i_wdata ({mem_addr, mem_data}),
    .i_pop   (w_grant_mem),
    .o_rdata (w_mem_head),
    .o_empty (w_mem_empty),
    .o_full  (w_mem_full)
  );

  // Round-robin grant: a lone non-empty source wins; on a tie the source
  // not granted most recently wins.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    if (!w_alu_empty && (w_mem_empty || r_last_grant == SRC_MEM)) w_grant_alu = 1'b1;
    else if (!w_mem_empty) w_grant_mem = 1'b1;
    w_sel      = w_grant_alu ? w_alu_head : w_mem_head;
    w_sel_addr = w_sel[EW-1:REG_WIDTH];
  end

  // Registered write port. Address 0 still loads A3/WD3 but never raises WE3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= SRC_MEM;
      r_we3        <= 1'b0;
      r_a3         <= '0;
      r_wd3        <= '0;
    end else begin
      r_we3 <= 1'b0;
      if (w_grant_alu || w_grant_mem) begin
        r_last_grant <= w_grant_alu ? SRC_ALU : SRC_MEM;
        r_we3        <= (w_sel_addr != '0);
        r_a3         <= w_sel_addr;
        r_wd3        <= w_sel[REG_WIDTH-1:0];
      end
    end
  end

  assign WE3  = r_we3;
  assign A3   = r_a3;
  assign WD3  = r_wd3;
  assign busy = !w_alu_empty || !w_mem_empty || r_we3;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: transaction-level reference queues produce
// expected writes; a negedge monitor pops and compares them against the port.
module tb_rf_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int AWB   = 5;
  localparam int DW    = 256;

  typedef struct {
    logic [AWB-1:0] a;
    logic [DW-1:0]  d;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           alu_valid = 1'b0, mem_valid = 1'b0;
  logic [AWB-1:0] alu_addr = '0, mem_addr = '0;
  logic [DW-1:0]  alu_data = '0, mem_data = '0;
  logic           alu_ready, mem_ready, WE3, busy;
  logic [AWB-1:0] A3;
  logic [DW-1:0]  WD3;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  ent_t qa[$], qm[$], exp_q[$];
  bit             m_last_mem = 1'b1;
  bit             m_we = 1'b0;
  logic [AWB-1:0] m_a3 = '0;
  logic [DW-1:0]  m_wd = '0;
  int             wr_log[$];
  logic [DW-1:0]  rf [32];
  bit             saw_alu_block = 1'b0;

  rf_writeback_arbiter #(.NUM_REGS(32), .REG_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
    end
  endtask

  // Transaction model: each edge, the rotating-priority winner among the
  // non-empty queues retires one entry; acceptance uses pre-edge occupancy.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete(); qm.delete(); exp_q.delete();
      m_last_mem = 1'b1; m_we = 1'b0; m_a3 = '0; m_wd = '0;
    end else begin
      bit acc_a, acc_m, take_a, take_m;
      ent_t e, na, nm;
      acc_a = alu_valid && (qa.size() < DEPTH);
      acc_m = mem_valid && (qm.size() < DEPTH);
      na.a = alu_addr; na.d = alu_data;
      nm.a = mem_addr; nm.d = mem_data;
      take_a = (qa.size() > 0) && ((qm.size() == 0) || m_last_mem);
      take_m = !take_a && (qm.size() > 0);
      m_we = 1'b0;
      if (take_a || take_m) begin
        e = take_a ? qa.pop_front() : qm.pop_front();
        m_last_mem = take_m;
        m_a3 = e.a;
        m_wd = e.d;
        if (e.a != 0) begin
          m_we = 1'b1;
          exp_q.push_back(e);
        end
      end
      if (acc_a) qa.push_back(na);
      if (acc_m) qm.push_back(nm);
    end
  end

  // Simple register file behind the write port.
  always @(posedge clk) if (rst && WE3) rf[A3] <= WD3;

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_WE3", DW'(WE3), '0);
      chk("rst_A3", DW'(A3), '0);
      chk("rst_WD3", WD3, '0);
      chk("rst_alu_ready", DW'(alu_ready), '0);
      chk("rst_mem_ready", DW'(mem_ready), '0);
      chk("rst_busy", DW'(busy), '0);
    end else begin
      if (!alu_ready) saw_alu_block = 1'b1;
      chk("alu_ready", DW'(alu_ready), DW'(qa.size() < DEPTH));
      chk("mem_ready", DW'(mem_ready), DW'(qm.size() < DEPTH));
      chk("busy", DW'(busy), DW'((qa.size() > 0) || (qm.size() > 0) || m_we));
      chk("WE3", DW'(WE3), DW'(m_we));
      if (WE3) begin
        chk("write_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          ent_t e;
          e = exp_q.pop_front();
          chk("sb_A3", DW'(A3), DW'(e.a));
          chk("sb_WD3", WD3, e.d);
        end
        wr_log.push_back(int'(A3));
      end
      chk("write_missing", DW'(exp_q.size()), '0);
      chk("A3", DW'(A3), DW'(m_a3));
      chk("WD3", WD3, m_wd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (qa.size() == 0 && qm.size() == 0 && !m_we) break;
      cyc();
    end
    cyc();
    chk("drain_busy", DW'(busy), '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Single write, addr 3
    wr_log.delete();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = {8{32'hAAAABEEF}};
    cyc();
    idle_inputs();
    wait_idle();
    chk("single_count", DW'(wr_log.size()), DW'(1));
    chk("rf_read3", rf[3], {8{32'hAAAABEEF}});

    // Tie arbitration from reset state
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = AWB'(1 + i);  alu_data = DW'(100 + i);
      mem_valid = 1'b1; mem_addr = AWB'(17 + i); mem_data = DW'(200 + i);
      cyc();
    end
    idle_inputs();
    wait_idle();
    begin
      int seq[6] = '{1, 17, 2, 18, 3, 19};
      chk("tie_count", DW'(wr_log.size()), DW'(6));
      for (int i = 0; i < 6 && i < wr_log.size(); i++) chk("tie_order", DW'(wr_log[i]), DW'(seq[i]));
    end

    // Backpressure: continuous two-source load
    saw_alu_block = 1'b0;
    for (int i = 0; i < 20; i++) begin
      alu_valid = 1'b1; alu_addr = AWB'(1 + (i % 15));  alu_data = DW'(32'h1000 + i);
      mem_valid = 1'b1; mem_addr = AWB'(16 + (i % 15)); mem_data = DW'(32'h2000 + i);
      cyc();
      if (alu_ready) alu_data = alu_data;
    end
    idle_inputs();
    wait_idle();
    chk("bp_alu_blocked", DW'(saw_alu_block), DW'(1));

    // Zero register then addr 7
    wr_log.delete();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = {8{32'hCAFEBABE}};
    cyc();
    alu_addr = 5'd7;
    cyc();
    idle_inputs();
    wait_idle();
    chk("zero_count", DW'(wr_log.size()), DW'(1));
    if (wr_log.size() > 0) chk("zero_then7", DW'(wr_log[0]), DW'(7));

    // MEM alone after an ALU grant
    wr_log.delete();
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = DW'(32'h55);
    cyc();
    idle_inputs();
    cyc();
    chk("mixed_we", DW'(WE3), DW'(1));
    chk("mixed_a3", DW'(A3), DW'(5));
    wait_idle();

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = AWB'(9 + i); alu_data = DW'(32'h900 + i);
      cyc();
    end
    idle_inputs();
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    wr_log.delete();
    #4;
    chk("post_rst_alu_ready", DW'(alu_ready), DW'(1));
    chk("post_rst_mem_ready", DW'(mem_ready), DW'(1));
    chk("post_rst_busy", DW'(busy), '0);
    for (int i = 0; i < 10; i++) cyc();
    chk("post_rst_no_write", DW'(wr_log.size()), '0);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 2) != 0);
      mem_valid = ($urandom_range(0, 2) != 0);
      alu_addr  = AWB'($urandom_range(0, 31));
      mem_addr  = AWB'($urandom_range(0, 31));
      alu_data  = {8{$urandom}};
      mem_data  = {8{$urandom}};
      if (i == 200) rst = 1'b0;
      if (i == 203) rst = 1'b1;
      cyc();
    end
    idle_inputs();
    wait_idle();
    chk("final_exp_empty", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Writeback stage that sits directly upstream of the 256-bit `Register_File` and owns its single write port (`WE3`/`A3`/`WD3`). It accepts results from two producers, the ALU/vector execute path and the memory/load path, over valid/ready handshakes, and buffers each in its own FIFO. It merges them round-robin into at most one register write per cycle. Writes to register 0 are consumed and discarded.

## Interface
- `NUM_REGS`, 32, number of architectural registers; sets `AW = $clog2(NUM_REGS)`.
- `REG_WIDTH`, 256, data width of one register.
- `FIFO_DEPTH`, 4, entries per source FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU FIFO can accept.
- `alu_addr`  in  AW  ALU destination register.
- `alu_data`  in  REG_WIDTH  ALU result.
- `mem_valid`  in  1  load result valid.
- `mem_ready`  out  1  load FIFO can accept.
- `mem_addr`  in  AW  load destination register.
- `mem_data`  in  REG_WIDTH  load data.
- `WE3`  out  1  register file write enable (registered).
- `A3`  out  AW  register file write address (registered).
- `WD3`  out  REG_WIDTH  register file write data (registered).
- `busy`  out  1  any entry queued or write in flight.

## Operation
- Push: the source FIFO captures {addr, data} on the edge where `x_valid && x_ready`. `x_ready = !full_x`, and it is forced 0 while `rst` is low.
- Full FIFO: no push even if a pop happens the same cycle. There is no pass-through, so `ready` depends only on stored count.
- Non-full FIFO with push and pop in the same cycle: count unchanged, both operations take effect.
- Arbiter, evaluated combinationally each cycle from FIFO empty flags:
  - neither non-empty → no grant;
  - one non-empty → grant it;
  - both non-empty → grant the source not granted most recently (`last_grant` register).
- `last_grant` updates only on a grant. It resets to MEM, so ALU wins the first tie.
- Granted entry is popped on the same edge that loads `A3`/`WD3`. `WE3` loads `(addr != 0)`.
- Entry with addr 0: popped, `A3`/`WD3` still load, `WE3` loads 0.
- No grant: `WE3` loads 0; `A3`/`WD3` hold their previous values.
- Ordering:
  - within one source, strict FIFO order;
  - across sources, arbitration order only. Same-register hazards between sources are the upstream's responsibility.
- Pointers: wrap modulo `FIFO_DEPTH`. Count is held in `$clog2(FIFO_DEPTH)+1` bits, so full and empty are distinguishable.
- `busy = !empty_alu || !empty_mem || WE3`.

## Timing
- Reset (`rst` low, asynchronous) values:
  - `WE3`=0, `A3`=0, `WD3`=0;
  - both FIFOs empty, pointers 0;
  - `last_grant`=MEM, `alu_ready`=`mem_ready`=0, `busy`=0.
- After `rst` rises, `x_ready` is 1 in the first cycle.
- Reset mid-operation discards all queued entries and any pending write. No stale write may appear after release.
- Latency: an entry accepted at edge N into an empty FIFO with no contention drives `WE3`=1 from edge N+1 to N+2. The register file commits it at edge N+2.
- `WE3` pulses for exactly one cycle per non-zero-address entry.
- Throughput: one write per cycle sustained. Under continuous two-source load each source gets 1/2 of the write port.

## Test plan
- Reset: queue 3 ALU entries, pull `rst` low mid-drain → `WE3`/`A3`/`WD3`=0 and ready=0 during reset; after release ready=1, busy=0, and no write appears within 10 cycles.
- Single write: ALU push addr 3, data `AAAABEEF` repeated ×8 at edge N → `WE3`=1 with `A3`=3 and that data for exactly the cycle after edge N+1; a register file read of register 3 returns it.
- Tie arbitration: both sources push every cycle (ALU addr 1,2,3,…; MEM addr 17,18,19,…) → `A3` sequence 1,17,2,18,3,19 with `WE3` continuously high.
- Backpressure, `FIFO_DEPTH`=4: both sources push continuously with sequence-numbered data for 20 cycles →
  - `x_ready` drops once the FIFO holds 4 entries;
  - every accepted entry is written exactly once, in per-source order;
  - no unaccepted entry is ever written.
- Zero register: ALU pushes addr 0 with data `CAFEBABE`×8, then addr 7 with data `CAFEBABE`×8 → addr 0 produces no `WE3` pulse; the addr 7 write follows one cycle later with `A3`=7.
- Mixed empty/non-empty: MEM alone pushes addr 5 while the ALU FIFO is empty → MEM is granted immediately despite `last_grant`=ALU; `A3`=5.
